nibble_serial_adder: RTL and testbench

Multi-cycle wide adder that feeds and consumes the team's 4-bit `carry_look_ahead_adder`. It accepts WIDTH-bit operands through a valid/ready handshake, presents one nibble per cycle to a single internal 4-bit CLA instance, and registers the CLA carry-out back into the next nibble's carry-in. It returns the full WIDTH-bit sum and the final carry through a valid/ready output handshake. It sits between an operand source (register file or bench driver) and any consumer that needs wide sums without a wide combinational carry chain.

---
 rtl/nibble_serial_adder.sv | 121 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit carry look-ahead slice, walked one nibble per
// cycle with the slice carry registered between nibbles.

module carry_look_ahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p, so no ripple inside the slice
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c_r;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_c;

  assign nib_a = a_r[4*idx +: 4];
  assign nib_b = b_r[4*idx +: 4];

  carry_look_ahead_adder u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (c_r),
    .s    (nib_s),
    .cout (nib_c)
  );

  // Decoded from state alone so the source never sees an input-to-ready path
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= 1'b0;
      idx       <= '0;
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            c_r   <= cin;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          s[4*idx +: 4] <= nib_s;
          c_r           <= nib_c;
          idx           <= idx + IW'(1);
          if (idx == LAST) begin
            cout      <= nib_c;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench: accepted operands queue their exact sum, monitors pop and
// compare whenever a result is presented, for a 16-bit and a 4-bit instance.

module tb_nibble_serial_adder;

  typedef struct {
    logic [16:0] sum;
    int          acc;
  } exp16_t;

  typedef struct {
    logic [4:0] sum;
    int         acc;
  } exp4_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;

  logic        in_valid4;
  logic        in_ready4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        cin4;
  logic        out_valid4;
  logic        out_ready4;
  logic [3:0]  s4;
  logic        cout4;

  int     cyc;
  int     checks;
  int     errors;
  int     hs_cyc;
  int     acc_hist[$];
  exp16_t q16[$];
  exp4_t  q4[$];
  exp16_t cur16;
  exp4_t  cur4;
  bit     hold16;
  bit     rnd_ready;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .s         (s4),
    .cout      (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 16-bit scoreboard: accepts push a+b+cin, presented results pop and compare
  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      hold16 = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        q16.push_back('{sum: {1'b0, a} + {1'b0, b} + 17'(cin), acc: cyc + 1});
        acc_hist.push_back(cyc + 1);
      end
      if (out_valid) begin
        if (!hold16) begin
          if (q16.size() == 0) begin
            checkOutput("spurious_out_valid16", 32'd1, 32'd0);
          end else begin
            cur16 = q16.pop_front();
            checkOutput("sum16", 32'({cout, s}), 32'(cur16.sum));
            checkOutput("latency16", 32'(cyc - cur16.acc), 32'd4);
            hold16 = 1'b1;
          end
        end else begin
          checkOutput("held_sum16", 32'({cout, s}), 32'(cur16.sum));
          checkOutput("in_ready_while_done", 32'(in_ready), 32'd0);
        end
        if (out_ready) begin
          hold16 = 1'b0;
          hs_cyc = cyc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
    end else begin
      if (in_valid4 && in_ready4)
        q4.push_back('{sum: {1'b0, a4} + {1'b0, b4} + 5'(cin4), acc: cyc + 1});
      if (out_valid4) begin
        if (q4.size() == 0) begin
          checkOutput("spurious_out_valid4", 32'd1, 32'd0);
        end else begin
          cur4 = q4.pop_front();
          checkOutput("sum4", 32'({cout4, s4}), 32'(cur4.sum));
          checkOutput("latency4", 32'(cyc - cur4.acc), 32'd1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                               input bit hold);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout16", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic applyStimulus4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    int n;
    @(posedge clk); #1;
    a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready4) checkOutput("accept_timeout4", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || q4.size() != 0 || out_valid || out_valid4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int first_acc;
    cyc = 0; checks = 0; errors = 0; hs_cyc = 0;
    hold16 = 1'b0; rnd_ready = 1'b0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum", 32'({cout, s}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed 16-bit cases");
    applyStimulus(16'h0003, 16'h0008, 1'b0, 1'b0);
    drain();
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    drain();

    // Back-to-back with in_valid held high: accepts must be exactly NIB+2 apart
    applyStimulus(16'h5555, 16'hAAAA, 1'b1, 1'b1);
    first_acc = acc_hist[$];
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    checkOutput("b2b_interval", 32'(acc_hist[$] - first_acc), 32'd6);
    drain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(16'hD013, 16'h8008, 1'b0, 1'b1);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 32'd0, 32'd1);
    first_acc = acc_hist.size();
    repeat (5) @(negedge clk);
    checkOutput("no_accept_under_backpressure", 32'(acc_hist.size()), 32'(first_acc));
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (acc_hist.size() == first_acc && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("accept_after_handshake", 32'(acc_hist[$] - hs_cyc), 32'd1);
    drain();

    $display("[TB] reset mid-operation");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_sum", 32'({cout, s}), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    drain();

    $display("[TB] randomized 16-bit traffic");
    rnd_ready = 1'b1;
    for (int i = 0; i < 30; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    rnd_ready = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("[TB] 4-bit instance");
    applyStimulus4(4'hD, 4'h8, 1'b0);
    applyStimulus4(4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 12; i++)
      applyStimulus4(4'($urandom), 4'($urandom), 1'($urandom));
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
